// File: rtl/mem_responder_if.sv
// mem_responder_if: cache-side external memory bus.
//   master modport (cache): drives addr/ren/wen/wdata, observes ready/rdata/valid.
//   slave modport (memory): drives ready/rdata/valid, observes addr/ren/wen/wdata.
//   ready : request may be accepted this cycle
//   addr  : byte address, bits [1:0] ignored by the responder
//   ren   : read request
//   wen   : write request
//   wdata : write data (full word)
//   rdata : read response data, zero when valid is low
//   valid : rdata carries a read response this cycle
interface mem_responder_if;
  logic        ready;
  logic [31:0] addr;
  logic        ren;
  logic        wen;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        valid;

  modport master (
    input  ready,
    input  rdata,
    input  valid,
    output addr,
    output ren,
    output wen,
    output wdata
  );

  modport slave (
    output ready,
    output rdata,
    output valid,
    input  addr,
    input  ren,
    input  wen,
    input  wdata
  );
endinterface

// File: rtl/mem_responder.sv
// mem_responder: word-granularity backing memory acting as the responder on the cache's
// external memory bus. Requests are accepted when ready is high; writes update the array on
// the accept edge and hold ready low for WRITE_BUSY cycles; reads sample the array on the
// accept edge and return in order READ_LATENCY edges later through a shift pipeline, with at
// most MAX_OUTSTANDING reads in flight.
//
// Ports:
//   i_clk       : clock, rising edge
//   i_rst_n     : synchronous active-low reset (array contents are kept)
//   mem         : slave side of mem_responder_if (ready/addr/ren/wen/wdata/rdata/valid)
//   o_proto_err : sticky flag, set when ren and wen are accepted together
//
// Optional build macro MEM_STALL_INJECT_EN: adds a 16-bit Fibonacci LFSR that masks ready
// on roughly a quarter of the cycles to exercise requester stall paths.
module mem_responder #(
  parameter int unsigned DEPTH_WORDS     = 1024,
  parameter int unsigned READ_LATENCY    = 2,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned WRITE_BUSY      = 1
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  mem_responder_if.slave mem,
  output logic           o_proto_err
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned BW = (WRITE_BUSY > 0) ? $clog2(WRITE_BUSY + 1) : 1;

  localparam logic [OW-1:0] MaxOut   = OW'(MAX_OUTSTANDING);
  localparam logic [BW-1:0] BusyLoad = BW'(WRITE_BUSY);

  logic [31:0]                   mem_q [DEPTH_WORDS];
  logic [AW-1:0]                 idx;
  logic                          req;
  logic                          ready;
  logic                          acc;
  logic                          acc_wr;
  logic                          acc_rd;
  logic                          acc_both;
  logic                          retire;
  logic                          stall;
  logic [31:0]                   rd_word;
  logic [READ_LATENCY-1:0]       vld_q;
  logic [READ_LATENCY-1:0][31:0] dat_q;
  logic [OW-1:0]                 out_q, out_d;
  logic [BW-1:0]                 wbusy_q, wbusy_d;
  logic                          perr_q, perr_d;
  logic                          unused_addr_bits;

  // Upper address bits alias by design; byte-offset bits carry no meaning for word access.
  assign idx              = mem.addr[AW+1:2];
  assign unused_addr_bits = ^{mem.addr[31:AW+2], mem.addr[1:0]};

`ifdef MEM_STALL_INJECT_EN
  logic [15:0] lfsr_q;

  // Taps 16,14,13,11 (bits 15,13,12,10); free-running outside reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      lfsr_q <= 16'hACE1;
    end else begin
      lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end
  end

  assign stall = (lfsr_q[1:0] == 2'b11);
`else
  assign stall = 1'b0;
`endif

  // The oldest entry leaves the pipeline at the end of the cycle it is presented.
  assign retire = vld_q[READ_LATENCY-1];

  // A retiring read frees its slot in time for a same-cycle accept, so a full pipeline
  // still sustains one read per cycle.
  always_comb begin
    ready = i_rst_n & (wbusy_q == '0) & ((out_q < MaxOut) | retire) & ~stall;
  end

  assign req      = mem.ren | mem.wen;
  assign acc      = req & ready;
  // Simultaneous ren/wen is handled as a write only.
  assign acc_wr   = acc & mem.wen;
  assign acc_rd   = acc & mem.ren & ~mem.wen;
  assign acc_both = acc & mem.ren & mem.wen;

  // Read-at-accept; idle slots carry zero so rdata is zero whenever valid is low.
  assign rd_word = acc_rd ? mem_q[idx] : 32'h0;

  // Array is intentionally not reset; acc already excludes the reset cycle.
  always_ff @(posedge i_clk) begin
    if (acc_wr) begin
      mem_q[idx] <= mem.wdata;
    end
  end

  if (READ_LATENCY == 1) begin : gen_lat1
    always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
        vld_q <= '0;
        dat_q <= '0;
      end else begin
        vld_q[0] <= acc_rd;
        dat_q[0] <= rd_word;
      end
    end
  end else begin : gen_latn
    always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
        vld_q <= '0;
        dat_q <= '0;
      end else begin
        vld_q <= {vld_q[READ_LATENCY-2:0], acc_rd};
        dat_q <= {dat_q[READ_LATENCY-2:0], rd_word};
      end
    end
  end

  always_comb begin
    out_d = out_q;
    if (acc_rd && !retire) begin
      out_d = out_q + OW'(1);
    end else if (!acc_rd && retire) begin
      out_d = out_q - OW'(1);
    end

    wbusy_d = wbusy_q;
    if (acc_wr) begin
      wbusy_d = BusyLoad;
    end else if (wbusy_q != '0) begin
      wbusy_d = wbusy_q - BW'(1);
    end

    perr_d = perr_q | acc_both;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      out_q   <= '0;
      wbusy_q <= '0;
      perr_q  <= 1'b0;
    end else begin
      out_q   <= out_d;
      wbusy_q <= wbusy_d;
      perr_q  <= perr_d;
    end
  end

  assign mem.ready   = ready;
  assign mem.valid   = vld_q[READ_LATENCY-1];
  assign mem.rdata   = dat_q[READ_LATENCY-1];
  assign o_proto_err = perr_q;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder. Two instances run side by side: one with default
// parameters and one with a small aliasing array, READ_LATENCY=4, MAX_OUTSTANDING=2 and
// WRITE_BUSY=2. A transaction-level model (word array plus a queue of expected responses
// with due times) predicts ready/valid/rdata/proto_err every cycle.
module tb_mem_responder;

  logic clk = 1'b0;
  logic rst_n;
  logic perr_a;
  logic perr_b;

  always #5 clk = ~clk;

  mem_responder_if mem_a ();
  mem_responder_if mem_b ();

  mem_responder u_dut_a (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .mem         (mem_a),
    .o_proto_err (perr_a)
  );

  mem_responder #(
    .DEPTH_WORDS     (16),
    .READ_LATENCY    (4),
    .MAX_OUTSTANDING (2),
    .WRITE_BUSY      (2)
  ) u_dut_b (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .mem         (mem_b),
    .o_proto_err (perr_b)
  );

  typedef struct {
    bit          nop;
    bit          ren;
    bit          wen;
    logic [31:0] addr;
    logic [31:0] wdata;
  } op_t;

  int lat   [2] = '{2, 4};
  int maxo  [2] = '{4, 2};
  int wbz   [2] = '{1, 2};
  int dmask [2] = '{1023, 15};

  op_t         opq    [2][$];
  logic [31:0] pq_dat [2][$];
  int          pq_due [2][$];
  logic [31:0] mm     [2][1024];
  int          wb_free[2];
  bit          perr_m [2];
  int          ec;
  int          checks = 0;
  int          errors = 0;

  function automatic bit exp_valid(int i);
    return (pq_due[i].size() > 0) && (pq_due[i][0] == ec);
  endfunction

  function automatic bit exp_ready(int i);
    return (ec >= wb_free[i]) && ((pq_due[i].size() < maxo[i]) || exp_valid(i));
  endfunction

  function automatic logic o_valid(int i);
    return (i == 0) ? mem_a.valid : mem_b.valid;
  endfunction

  function automatic logic o_ready(int i);
    return (i == 0) ? mem_a.ready : mem_b.ready;
  endfunction

  function automatic logic [31:0] o_rdata(int i);
    return (i == 0) ? mem_a.rdata : mem_b.rdata;
  endfunction

  function automatic logic o_perr(int i);
    return (i == 0) ? perr_a : perr_b;
  endfunction

  function automatic string tag(string name, int i);
    return $sformatf("%s_%s@e%0d", name, (i == 0) ? "a" : "b", ec);
  endfunction

  task automatic chk(string name, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h, expected 0x%08h", name, obs, exp);
    end
  endtask

  task automatic drive(int i, bit ren, bit wen, logic [31:0] addr, logic [31:0] wd);
    if (i == 0) begin
      mem_a.ren = ren; mem_a.wen = wen; mem_a.addr = addr; mem_a.wdata = wd;
    end else begin
      mem_b.ren = ren; mem_b.wen = wen; mem_b.addr = addr; mem_b.wdata = wd;
    end
  endtask

  task automatic push_op(bit ren, bit wen, logic [31:0] addr, logic [31:0] wd);
    op_t op;
    op.nop = 1'b0; op.ren = ren; op.wen = wen; op.addr = addr; op.wdata = wd;
    for (int i = 0; i < 2; i++) opq[i].push_back(op);
  endtask

  task automatic push_nop();
    op_t op;
    op.nop = 1'b1; op.ren = 1'b0; op.wen = 1'b0; op.addr = '0; op.wdata = '0;
    for (int i = 0; i < 2; i++) opq[i].push_back(op);
  endtask

  // Check the current cycle, present the next request and advance the model by one edge.
  task automatic tick();
    bit          rdy [2];
    bit          vld [2];
    bit          ren, wen, acc_rd;
    logic [31:0] addr, wd, rd_data;
    int          idx;
    op_t         op;
    for (int i = 0; i < 2; i++) begin
      rdy[i] = exp_ready(i);
      vld[i] = exp_valid(i);
      chk(tag("valid", i), 32'(o_valid(i)), 32'(vld[i]));
      chk(tag("rdata", i), o_rdata(i), vld[i] ? pq_dat[i][0] : 32'h0);
      chk(tag("ready", i), 32'(o_ready(i)), 32'(rdy[i]));
      chk(tag("perr", i), 32'(o_perr(i)), 32'(perr_m[i]));
    end
    for (int i = 0; i < 2; i++) begin
      ren = 1'b0; wen = 1'b0; addr = '0; wd = '0; acc_rd = 1'b0; rd_data = '0;
      if (opq[i].size() > 0) begin
        op = opq[i][0];
        if (op.nop) begin
          void'(opq[i].pop_front());
        end else begin
          ren = op.ren; wen = op.wen; addr = op.addr; wd = op.wdata;
          if (rdy[i]) begin
            idx = int'((op.addr >> 2) & 32'(dmask[i]));
            if (op.wen) begin
              mm[i][idx] = op.wdata;
              wb_free[i] = ec + 1 + wbz[i];
              if (op.ren) perr_m[i] = 1'b1;
            end else begin
              acc_rd  = 1'b1;
              rd_data = mm[i][idx];
            end
            void'(opq[i].pop_front());
          end
        end
      end
      if (vld[i]) begin
        void'(pq_dat[i].pop_front());
        void'(pq_due[i].pop_front());
      end
      if (acc_rd) begin
        pq_dat[i].push_back(rd_data);
        pq_due[i].push_back(ec + lat[i]);
      end
      drive(i, ren, wen, addr, wd);
    end
    @(posedge clk);
    ec++;
    #1;
  endtask

  function automatic bit busy();
    return (opq[0].size() > 0) || (opq[1].size() > 0) ||
           (pq_due[0].size() > 0) || (pq_due[1].size() > 0);
  endfunction

  task automatic drain(string name, int bound);
    int n = 0;
    while (busy() && n < bound) begin
      tick();
      n++;
    end
    chk({"drain_", name}, 32'(busy()), 32'h0);
  endtask

  task automatic do_reset(int cycles);
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) drive(i, 1'b0, 1'b0, '0, '0);
    #1;
    for (int i = 0; i < 2; i++) chk(tag("rst_ready_comb", i), 32'(o_ready(i)), 32'h0);
    repeat (cycles) begin
      @(posedge clk);
      ec++;
      #1;
      for (int i = 0; i < 2; i++) begin
        chk(tag("rst_valid", i), 32'(o_valid(i)), 32'h0);
        chk(tag("rst_rdata", i), o_rdata(i), 32'h0);
        chk(tag("rst_ready", i), 32'(o_ready(i)), 32'h0);
        chk(tag("rst_perr", i), 32'(o_perr(i)), 32'h0);
      end
    end
    for (int i = 0; i < 2; i++) begin
      opq[i].delete();
      pq_dat[i].delete();
      pq_due[i].delete();
      wb_free[i] = 0;
      perr_m[i]  = 1'b0;
    end
    rst_n = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) chk(tag("post_rst_ready", i), 32'(o_ready(i)), 32'h1);
  endtask

  initial begin
    logic [31:0] a;
    int          r;
    ec = 0;
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) drive(i, 1'b0, 1'b0, '0, '0);
    do_reset(3);

    // Write then read back.
    push_op(1'b0, 1'b1, 32'h40, 32'hDEAD_BEEF);
    push_op(1'b1, 1'b0, 32'h40, '0);
    drain("wr_rd", 50);

    // Preload the 16-word window used later; first four words are the line-fill pattern.
    for (int w = 0; w < 16; w++) begin
      push_op(1'b0, 1'b1, 32'h100 + 32'(w * 4), (w < 4) ? 32'(w + 1) : $urandom());
    end
    drain("preload", 200);

    // Line fill on consecutive cycles.
    for (int w = 0; w < 4; w++) push_op(1'b1, 1'b0, 32'h100 + 32'(w * 4), '0);
    drain("line_fill", 50);

    // Read-at-accept against a following write to the same word.
    push_op(1'b0, 1'b1, 32'h80, 32'h11);
    drain("raa_init", 50);
    push_op(1'b1, 1'b0, 32'h80, '0);
    push_op(1'b0, 1'b1, 32'h80, 32'h22);
    push_op(1'b1, 1'b0, 32'h80, '0);
    drain("raa", 50);

    // Back-to-back reads; exercises the outstanding cap on the second instance.
    for (int n = 0; n < 8; n++) push_op(1'b1, 1'b0, 32'h100 + 32'((n % 16) * 4), '0);
    drain("cap", 100);

    // Random traffic over an aliased 16-word window, including ignored upper/low bits.
    for (int n = 0; n < 200; n++) begin
      r = $urandom_range(0, 9);
      a = ($urandom() & 32'hFFFF_F000) | (32'(64 + $urandom_range(0, 15)) << 2) |
          32'($urandom_range(0, 3));
      if (r < 4) push_op(1'b1, 1'b0, a, '0);
      else if (r < 7) push_op(1'b0, 1'b1, a, $urandom());
      else push_nop();
    end
    drain("random", 4000);

    // Simultaneous ren/wen: a write, no response, sticky error.
    push_op(1'b1, 1'b1, 32'h20, 32'h5);
    push_nop();
    push_nop();
    push_op(1'b1, 1'b0, 32'h20, '0);
    drain("proto", 50);

    // Reset with reads in flight.
    push_op(1'b1, 1'b0, 32'h100, '0);
    push_op(1'b1, 1'b0, 32'h104, '0);
    for (int n = 0; n < 20 && (opq[0].size() > 0 || opq[1].size() > 0); n++) tick();
    chk("midflight_accepts", 32'(opq[0].size() + opq[1].size()), 32'h0);
    do_reset(1);
    for (int n = 0; n < 6; n++) push_nop();
    push_op(1'b1, 1'b0, 32'h100, '0);
    push_op(1'b1, 1'b0, 32'h104, '0);
    push_op(1'b1, 1'b0, 32'h20, '0);
    drain("post_reset", 100);
    repeat (4) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
# mem_responder

Word-granularity backing-memory model that acts as the responder on the cache's external memory interface (ready / addr / ren / wen / wdata / rdata / valid). It sits below the instruction and data caches in simulation and FPGA builds. It accepts pipelined read and write requests under an `o_mem_ready` handshake and returns read data in order, a fixed number of cycles after acceptance. It also models post-write busy time and a cap on outstanding reads.

## Interface
- `DEPTH_WORDS`, 1024: number of 32-bit words; power of two, ≥ 4.
- `READ_LATENCY`, 2: rising edges from acceptance to response; ≥ 1.
- `MAX_OUTSTANDING`, 4: maximum reads accepted but not yet returned; ≥ 1.
- `WRITE_BUSY`, 1: cycles `o_mem_ready` stays low after an accepted write; 0 disables.
- `i_clk`  in  1  single clock, rising edge.
- `i_rst_n`  in  1  synchronous, active-low reset.
- `o_mem_ready`  out  1  request may be accepted this cycle.
- `i_mem_addr`  in  32  byte address; bits [1:0] ignored.
- `i_mem_ren`  in  1  read request.
- `i_mem_wen`  in  1  write request.
- `i_mem_wdata`  in  32  write data (full word).
- `o_mem_rdata`  out  32  read response data.
- `o_mem_valid`  out  1  `o_mem_rdata` valid this cycle.
- `o_proto_err`  out  1  sticky; set on a protocol violation.

## Operation
- Word index = `i_mem_addr[log2(DEPTH_WORDS)+1:2]`. Upper bits are ignored, so out-of-range addresses alias.
- Accept: `(i_mem_ren | i_mem_wen) & o_mem_ready` at a rising edge. Requests made while `o_mem_ready` is low are ignored; no state change.
- Write: the array word is updated on the accept edge. The WRITE_BUSY down-counter loads `WRITE_BUSY` on that edge.
- Read: the array word is sampled on the accept edge (read-at-accept). It enters a READ_LATENCY-deep valid/data shift pipeline, and the outstanding counter increments.
  - A later write to the same word does not affect an in-flight read.
  - A read accepted the cycle after a write to the same word returns the new data.
- Retire: when an entry leaves the pipeline, `o_mem_valid`=1 for one cycle and the outstanding counter decrements. Responses return in acceptance order.
- Simultaneous retire and new read accept: the counter is unchanged.
- `o_mem_ready` = `i_rst_n & (wbusy_cnt==0) & (outstanding<MAX_OUTSTANDING | retiring this cycle)` [& stall mask, see Configuration]. It is combinational from registered state.
- `i_mem_ren & i_mem_wen` in the same cycle:
  - If `o_mem_ready`=1: treated as a write only, and `o_proto_err` is set.
  - If `o_mem_ready`=0: no effect.
- `o_proto_err` clears only on reset.
- Reset:
  - Outputs: `o_mem_ready`=0, `o_mem_valid`=0, `o_mem_rdata`=0, `o_proto_err`=0.
  - The pipeline, counters and stall state are cleared.
  - Array contents are not reset.
- Reset mid-operation: in-flight reads are dropped; no `o_mem_valid` is produced for them after reset release.
- `o_mem_rdata` = 0 whenever `o_mem_valid`=0.

## Timing
- Read accepted at edge k: `o_mem_valid`=1 in the cycle following edge k+READ_LATENCY−1. With READ_LATENCY=1, the response appears in the cycle immediately after acceptance.
- Back-to-back reads, one per cycle, are sustained as long as MAX_OUTSTANDING ≥ READ_LATENCY. This covers the cache's 4-word line fill on consecutive cycles.
- Write accepted at edge k: `o_mem_ready`=0 for the next WRITE_BUSY cycles, then high again if no other condition holds it low.
- First cycle after `i_rst_n` rises: `o_mem_ready`=1, unless stall injection masks it.
- Throughput: one request per cycle maximum. Writes have no response.

## Configuration
- Macro: `MEM_STALL_INJECT_EN`.
- Defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11), seeded 16'hACE1 on reset, advances every cycle.
  - `o_mem_ready` is additionally forced 0 when `lfsr[1:0]==2'b11`, giving about 25% pseudo-random stall cycles to exercise cache stall paths.
  - Accept and retire rules are otherwise unchanged; in-flight reads still return on schedule.
- Undefined: no LFSR is instantiated and `o_mem_ready` is purely rule-based.

## Test plan
- Write and read back: after reset, write 0xDEADBEEF to 0x40 and wait out WRITE_BUSY; read 0x40 → `o_mem_valid` exactly READ_LATENCY edges after accept, rdata 0xDEADBEEF.
- Line fill: preload 0x100–0x10C with 1, 2, 3, 4; issue reads on 4 consecutive cycles → 4 consecutive valids returning 1, 2, 3, 4 in order, with `o_mem_ready` never dropping (defaults).
- Outstanding cap: MAX_OUTSTANDING=2, READ_LATENCY=4; request reads every cycle → `o_mem_ready` low after 2 accepts, re-rises in the retire cycle; every accepted read returns exactly once.
- Read-at-accept: accept a read of 0x80 (old 0x11), then on the next ready cycle write 0x22 to 0x80 → the read returns 0x11; a subsequent read returns 0x22.
- Protocol error: assert ren and wen together with ready=1 at 0x20 with data 0x5 → the word is written, no `o_mem_valid`, `o_proto_err`=1 until reset.
- Reset mid-flight: accept 2 reads, then pull `i_rst_n` low for 1 cycle → no valids afterwards, `o_mem_ready`=0 during reset and 1 after; memory contents are preserved.
